// File: rtl/mem_arbiter.sv
// Shares one single-port SRAM between IF (read) and MEM (read/write); MEM has fixed priority.
// Latency: ack WAIT_CYCLES+2 cycles after grant; backpressure via level req held until ack, stalls = req && !ack.
module mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,
    output logic              ram_ce_o,
    output logic              ram_oe_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              if_stall_o,
    output logic              mem_stall_o,
    output logic              busy_o
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                gnt_mem_q, gnt_mem_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                if_ack_q, if_ack_d;
    logic                mem_ack_q, mem_ack_d;
    logic [DATA_W-1:0]   if_data_q, if_data_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                mem_elig, if_elig;

    // A requester whose ack is showing this cycle has already been served.
    assign mem_elig = mem_req_i && !mem_ack_q;
    assign if_elig  = if_req_i && !if_ack_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_mem_d   = gnt_mem_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            IDLE: begin
                if (mem_elig) begin
                    gnt_mem_d = 1'b1;
                    addr_d    = mem_addr_i;
                    we_d      = mem_we_i;
                    wdata_d   = mem_wdata_i;
                    cnt_d     = WAIT_INIT;
                    state_d   = BUSY;
                end else if (if_elig) begin
                    gnt_mem_d = 1'b0;
                    addr_d    = if_addr_i;
                    we_d      = 1'b0;
                    cnt_d     = WAIT_INIT;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d = IDLE;
                    if (gnt_mem_q) begin
                        mem_ack_d = 1'b1;
                        if (!we_q) mem_rdata_d = ram_rdata_i;
                    end else begin
                        if_ack_d  = 1'b1;
                        if_data_d = ram_rdata_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            gnt_mem_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_mem_q   <= gnt_mem_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Strobes decode only from registered state so they cannot glitch on request edges;
    // WE drops on the last BUSY cycle to give address/data hold time.
    assign busy_o      = (state_q == BUSY);
    assign ram_ce_o    = busy_o;
    assign ram_oe_o    = busy_o && !we_q;
    assign ram_we_o    = busy_o && we_q && ((cnt_q != 3'd0) || ZERO_WAIT);
    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;

    assign if_ack_o    = if_ack_q;
    assign mem_ack_o   = mem_ack_q;
    assign if_data_o   = if_data_q;
    assign mem_rdata_o = mem_rdata_q;
    assign if_stall_o  = if_req_i && !if_ack_q;
    assign mem_stall_o = mem_req_i && !mem_ack_q;

endmodule
